// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU job sequencer.
// State encoding, ALU opcodes, flag bit positions and the ALU nibble mux.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALU_CLR,
      SEND_OP1,
      SEND_OP2,
      SEND_OPC,
      WAIT_DONE,
      RESPOND
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_NAND = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;

   localparam int FLAG_DONE  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_SIGN  = 3;

   // Nibble presented to the ALU for a given sequencer state.
   function automatic logic [3:0] alu_nibble(
      input state_t     s,
      input logic [3:0] op1,
      input logic [3:0] op2,
      input logic [3:0] opc
   );
      logic [3:0] n;
      n = 4'h0;
      unique case (s)
         SEND_OP1: n = op1;
         SEND_OP2: n = op2;
         SEND_OPC: n = opc;
         default:  n = 4'h0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/alu_job_sequencer_if.sv
// Requester handshake bundle between the sequencer and its arbiter.
// The master offers valid bits and a take strobe; the slave answers with ready and the granted id.
interface alu_job_sequencer_if;

   logic [1:0] valid;
   logic [1:0] ready;
   logic       take;
   logic       gnt_id;

   modport master (
      output valid,
      output take,
      input  ready,
      input  gnt_id
   );

   modport slave (
      input  valid,
      input  take,
      output ready,
      output gnt_id
   );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; requester 0 wins first after reset.
// A grant is only issued while the master raises take.
module rr_arbiter_2
   import alu_seq_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   alu_job_sequencer_if.slave  arb
);

   logic last;
   logic pick;

   always_comb begin
      pick = 1'b0;
      unique case (1'b1)
         arb.valid[0] && arb.valid[1]:  pick = ~last;
         arb.valid[1] && !arb.valid[0]: pick = 1'b1;
         default:                       pick = 1'b0;
      endcase
   end

   assign arb.gnt_id   = pick;
   assign arb.ready[0] = arb.take && arb.valid[0] && !pick;
   assign arb.ready[1] = arb.take && arb.valid[1] && pick;

   // last starts at 1 so requester 0 is preferred on the first contest
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last <= 1'b1;
      end else if (arb.take && (|arb.valid)) begin
         last <= pick;
      end
   end

endmodule

// File: rtl/alu_job_sequencer.sv
// Serialises jobs from two requesters onto a nibble-wide ALU and returns results.
// Define ALU_SEQ_TIMEOUT_EN to abort jobs whose done flag never arrives.
module alu_job_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DONE_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0_valid,
   input  logic       req1_valid,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic [3:0] req0_op1,
   input  logic [3:0] req0_op2,
   input  logic [3:0] req0_opcode,
   input  logic [3:0] req1_op1,
   input  logic [3:0] req1_op2,
   input  logic [3:0] req1_opcode,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic       rsp_timeout,
   output logic [3:0] rsp_result,
   output logic [2:0] rsp_flags,
   output logic       alu_reset,
   output logic [3:0] alu_data,
   input  logic [3:0] alu_result,
   input  logic [3:0] alu_flags,
   output logic       busy
);

   state_t     state;
   state_t     next;
   logic [3:0] op1_q;
   logic [3:0] op2_q;
   logic [3:0] opc_q;
   logic       id_q;
   logic       clr_hold;
   logic       accept;
   logic       done;
   logic       expired;

   alu_job_sequencer_if arb ();

   assign arb.valid  = {req1_valid, req0_valid};
   assign arb.take   = (state == IDLE);
   assign req0_ready = arb.ready[0];
   assign req1_ready = arb.ready[1];
   assign accept     = |arb.ready;
   assign done       = alu_flags[FLAG_DONE];

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .arb     (arb)
   );

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

   logic [7:0] wait_cnt;

   assign expired = !done && (wait_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 8'd0;
      end else if (state != WAIT_DONE) begin
         wait_cnt <= 8'd0;
      end else begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo  = ^8'(DONE_TIMEOUT);
   assign expired     = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:      if (accept) next = ALU_CLR;
         ALU_CLR:   next = SEND_OP1;
         SEND_OP1:  next = SEND_OP2;
         SEND_OP2:  next = SEND_OPC;
         SEND_OPC:  next = WAIT_DONE;
         WAIT_DONE: if (done || expired) next = RESPOND;
         RESPOND:   next = IDLE;
         default:   next = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESPOND);
   assign alu_data  = alu_nibble(state, op1_q, op2_q, opc_q);
   assign alu_reset = clr_hold || (state == ALU_CLR);

   // Keeps the ALU in reset until the first edge after reset_n releases
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_hold <= 1'b1;
      end else begin
         clr_hold <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op1_q <= 4'h0;
         op2_q <= 4'h0;
         opc_q <= 4'h0;
         id_q  <= 1'b0;
      end else if (accept) begin
         op1_q <= arb.gnt_id ? req1_op1    : req0_op1;
         op2_q <= arb.gnt_id ? req1_op2    : req0_op2;
         opc_q <= arb.gnt_id ? req1_opcode : req0_opcode;
         id_q  <= arb.gnt_id;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_result <= 4'h0;
         rsp_flags  <= 3'b000;
         rsp_id     <= 1'b0;
      end else if (state == WAIT_DONE) begin
         if (done) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags[FLAG_SIGN:FLAG_CARRY];
            rsp_id     <= id_q;
         end else if (expired) begin
            rsp_result <= 4'h0;
            rsp_flags  <= 3'b000;
            rsp_id     <= id_q;
         end
      end
   end

`ifdef ALU_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_timeout <= 1'b0;
      end else if (state == WAIT_DONE) begin
         if (done) begin
            rsp_timeout <= 1'b0;
         end else if (expired) begin
            rsp_timeout <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_job_sequencer.sv
// Directed bench for alu_job_sequencer with a behavioural nibble ALU.
// Build with ALU_SEQ_TIMEOUT_EN defined to also cover the done timeout.
module tb_alu_job_sequencer;
   import alu_seq_pkg::*;

   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req0_op1, req0_op2, req0_opcode;
   logic [3:0] req1_op1, req1_op2, req1_opcode;
   logic       rsp_valid, rsp_id, rsp_timeout;
   logic [3:0] rsp_result;
   logic [2:0] rsp_flags;
   logic       alu_reset;
   logic [3:0] alu_data;
   logic [3:0] alu_result;
   logic [3:0] alu_flags;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_job_sequencer_if rq ();

   alu_job_sequencer #(.DONE_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0_valid  (rq.valid[0]),
      .req1_valid  (rq.valid[1]),
      .req0_ready  (rq.ready[0]),
      .req1_ready  (rq.ready[1]),
      .req0_op1    (req0_op1),
      .req0_op2    (req0_op2),
      .req0_opcode (req0_opcode),
      .req1_op1    (req1_op1),
      .req1_op2    (req1_op2),
      .req1_opcode (req1_opcode),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_timeout (rsp_timeout),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags),
      .alu_reset   (alu_reset),
      .alu_data    (alu_data),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .busy        (busy)
   );

   // Behavioural ALU: after reset it takes op1, op2, opcode, then raises done
   logic [3:0] m_a, m_b, m_op, m_r;
   logic       m_c;
   int         m_n;
   logic       stuck = 1'b0;

   always @(posedge clk) begin
      if (alu_reset) begin
         m_n <= 0;
      end else if (m_n < 3) begin
         if (m_n == 0) m_a <= alu_data;
         if (m_n == 1) m_b <= alu_data;
         if (m_n == 2) m_op <= alu_data;
         m_n <= m_n + 1;
      end
   end

   always_comb begin
      m_r = 4'h0;
      m_c = 1'b0;
      case (m_op)
         OP_ADD:  {m_c, m_r} = {1'b0, m_a} + {1'b0, m_b};
         OP_SUB:  begin m_r = m_a - m_b; m_c = (m_a < m_b); end
         OP_AND:  m_r = m_a & m_b;
         OP_OR:   m_r = m_a | m_b;
         OP_NOT:  m_r = ~m_a;
         OP_NAND: m_r = ~(m_a & m_b);
         OP_NOR:  m_r = ~(m_a | m_b);
         default: m_r = 4'h0;
      endcase
   end

   assign alu_result = m_r;
   assign alu_flags  = {m_r[3], (m_r == 4'h0), m_c, (m_n == 3) && !stuck};

   typedef struct {
      logic       id;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] op;
      logic [3:0] res;
      logic [2:0] flg;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic accept(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, output int waits);
      if (id) begin
         req1_op1 = a; req1_op2 = b; req1_opcode = op;
      end else begin
         req0_op1 = a; req0_op2 = b; req0_opcode = op;
      end
      rq.valid[id] = 1'b1;
      waits = -1;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (rq.ready[id]) begin
            waits = i;
            break;
         end
         @(negedge clk);
      end
      chk("accept_seen", 32'(waits >= 0), 32'd1);
      chk("other_ready_low", 32'(rq.ready[~id]), 32'd0);
      @(negedge clk);
      rq.valid[id] = 1'b0;
   endtask

   // Returns at the negedge where rsp_valid is high; lat counts from the accept cycle
   task automatic wait_rsp(input int start, output int lat);
      lat = -1;
      for (int c = start; c < 60; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic job(input string nm, input logic id, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] op,
                      input logic [3:0] res, input logic [2:0] flg);
      int w, lat;
      accept(id, a, b, op, w);
      wait_rsp(2, lat);
      chk({nm, "_latency"}, 32'(lat), 32'd6);
      chk({nm, "_id"}, 32'(rsp_id), 32'(id));
      chk({nm, "_result"}, 32'(rsp_result), 32'(res));
      chk({nm, "_flags"}, 32'(rsp_flags), 32'(flg));
      chk({nm, "_timeout"}, 32'(rsp_timeout), 32'd0);
      @(negedge clk);
      chk({nm, "_pulse"}, 32'(rsp_valid), 32'd0);
      chk({nm, "_hold"}, 32'(rsp_result), 32'(res));
   endtask

   initial begin
      int w, lat, gid, hits;
      string nm;
      rq.valid = 2'b00;
      req0_op1 = 4'h0; req0_op2 = 4'h0; req0_opcode = 4'h0;
      req1_op1 = 4'h0; req1_op2 = 4'h0; req1_opcode = 4'h0;

      vt[0] = '{1'b0, 4'h3, 4'h4, OP_ADD,  4'h7, 3'b000};
      vt[1] = '{1'b1, 4'h9, 4'h9, OP_ADD,  4'h2, 3'b001};
      vt[2] = '{1'b0, 4'h5, 4'h7, OP_SUB,  4'hE, 3'b101};
      vt[3] = '{1'b1, 4'hC, 4'hA, OP_AND,  4'h8, 3'b100};
      vt[4] = '{1'b0, 4'h5, 4'h5, OP_SUB,  4'h0, 3'b010};
      vt[5] = '{1'b1, 4'h3, 4'h0, OP_NOT,  4'hC, 3'b100};
      vt[6] = '{1'b0, 4'hC, 4'hA, OP_OR,   4'hE, 3'b100};
      vt[7] = '{1'b1, 4'hF, 4'h1, OP_ADD,  4'h0, 3'b011};
      vt[8] = '{1'b0, 4'hF, 4'hF, OP_NAND, 4'h0, 3'b010};
      vt[9] = '{1'b1, 4'h2, 4'h4, OP_NOR,  4'h9, 3'b100};

      repeat (2) @(negedge clk);
      chk("rst_alu_reset", 32'(alu_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_timeout, rsp_result, rsp_flags}, 32'd0);
      chk("rst_ready", 32'(rq.ready), 32'd0);
      chk("rst_alu_data", 32'(alu_data), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_alu_reset_fall", 32'(alu_reset), 32'd0);

      foreach (vt[i]) begin
         nm = $sformatf("vec%0d", i);
         job(nm, vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].res, vt[i].flg);
      end

      // Round robin with both requesters continuously valid
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      req0_op1 = 4'h1; req0_op2 = 4'h2; req0_opcode = OP_ADD;
      req1_op1 = 4'h4; req1_op2 = 4'h4; req1_opcode = OP_ADD;
      rq.valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         gid = -1;
         for (int i = 0; i < 30; i++) begin
            #1;
            if (|rq.ready) begin
               gid = int'(rq.ready[1]);
               chk("rr_onehot", 32'(rq.ready), (gid == 1) ? 32'd2 : 32'd1);
               break;
            end
            @(negedge clk);
         end
         chk($sformatf("rr_grant%0d", k), 32'(gid), 32'(k % 2));
         @(negedge clk);
         wait_rsp(2, lat);
         chk($sformatf("rr_rsp_id%0d", k), 32'(rsp_id), 32'(k % 2));
         chk($sformatf("rr_rsp_res%0d", k), 32'(rsp_result), (k % 2) ? 32'd8 : 32'd3);
      end
      rq.valid = 2'b00;
      @(negedge clk);

      // Request raised during RESPOND is taken on the following IDLE cycle
      accept(1'b0, 4'h2, 4'h3, OP_ADD, w);
      wait_rsp(2, lat);
      chk("resp_rsp", 32'(rsp_result), 32'd5);
      req0_op1 = 4'hA; req0_op2 = 4'h4; req0_opcode = OP_SUB;
      rq.valid[0] = 1'b1;
      #1;
      chk("resp_no_ready", 32'(rq.ready[0]), 32'd0);
      @(negedge clk);
      accept(1'b0, 4'hA, 4'h4, OP_SUB, w);
      chk("resp_next_accept", 32'(w), 32'd0);
      chk("seq_clr", 32'(alu_data), 32'd0);
      @(negedge clk);
      chk("seq_op1", 32'(alu_data), 32'hA);
      @(negedge clk);
      chk("seq_op2", 32'(alu_data), 32'h4);
      @(negedge clk);
      chk("seq_opc", 32'(alu_data), 32'(OP_SUB));
      wait_rsp(5, lat);
      chk("seq_latency", 32'(lat), 32'd6);
      chk("seq_result", 32'(rsp_result), 32'd6);
      @(negedge clk);

      // Reset in SEND_OP2 drops the job
      accept(1'b1, 4'h6, 4'h1, OP_ADD, w);
      @(negedge clk);
      @(negedge clk);
      chk("mid_op2_data", 32'(alu_data), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_alu_reset", 32'(alu_reset), 32'd1);
      chk("mid_alu_data", 32'(alu_data), 32'd0);
      chk("mid_rsp", {rsp_valid, rsp_id, rsp_result}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid_alu_reset_hold", 32'(alu_reset), 32'd1);
      @(negedge clk);
      chk("mid_alu_reset_fall", 32'(alu_reset), 32'd0);
      hits = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid || busy) hits++;
      end
      chk("mid_no_rsp", 32'(hits), 32'd0);
      job("post_rst", 1'b0, 4'h6, 4'h1, OP_ADD, 4'h7, 3'b000);

`ifdef ALU_SEQ_TIMEOUT_EN
      stuck = 1'b1;
      accept(1'b0, 4'h3, 4'h4, OP_ADD, w);
      wait_rsp(2, lat);
      chk("tmo_latency", 32'(lat), 32'(TMO + 5));
      chk("tmo_flag", 32'(rsp_timeout), 32'd1);
      chk("tmo_result", 32'(rsp_result), 32'd0);
      chk("tmo_flags", 32'(rsp_flags), 32'd0);
      stuck = 1'b0;
      @(negedge clk);
      job("after_tmo", 1'b1, 4'h9, 4'h9, OP_ADD, 4'h2, 3'b001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_job_sequencer.md
ALU_JOB_SEQUENCER -- requirements
Module: alu_job_sequencer

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 8, giving the maximum WAIT_DONE cycles before a job is aborted (range 1..255).
REQ-002 SHALL have port clk  in  1  single rising-edge clock.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  in  1 each  job offered by requester 0/1.
REQ-005 SHALL have ports req0_ready, req1_ready  out  1 each  job accepted this cycle.
REQ-006 SHALL have ports reqN_op1, reqN_op2, reqN_opcode  in  4 each  operands and opcode per requester.
REQ-007 SHALL have ports rsp_valid, rsp_id, rsp_timeout  out  1 each  response strobe, owning requester, abort flag.
REQ-008 SHALL have ports rsp_result  out  4 and rsp_flags  out  3  ALU result and {sign, zero, carry}.
REQ-009 SHALL have ports alu_reset  out  1 and alu_data  out  4  active-high synchronous ALU reset and ALU nibble input.
REQ-010 SHALL have ports alu_result  in  4 and alu_flags  in  4  ALU outputs {sign, zero, carry, done}.
REQ-011 SHALL have port busy  out  1, high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM IDLE -> ALU_CLR -> SEND_OP1 -> SEND_OP2 -> SEND_OPC -> WAIT_DONE -> RESPOND -> IDLE, with one cycle per state except WAIT_DONE.
REQ-013 SHALL, in IDLE with any reqN_valid high, assert exactly one reqN_ready for one cycle, capture that job's payload and requester id, and go to ALU_CLR.
REQ-014 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; after reset requester 0 has priority.
REQ-015 SHALL keep both reqN_ready low outside IDLE; requesters hold valid and payload stable until ready.
REQ-016 SHALL drive alu_reset=1 only in ALU_CLR (and during reset), alu_data=op1 in SEND_OP1, op2 in SEND_OP2, opcode unmodified in SEND_OPC, and alu_data=0 in all other states.
REQ-017 SHALL, in WAIT_DONE, register alu_result and alu_flags[3:1] and go to RESPOND on the first cycle alu_flags[0]=1.
REQ-018 SHALL pulse rsp_valid for exactly one cycle in RESPOND; rsp_result, rsp_flags, rsp_id and rsp_timeout SHALL hold until the next RESPOND.
REQ-019 SHALL give a latency of 6 cycles from the accept cycle to rsp_valid when done is seen on the first WAIT_DONE cycle.
REQ-020 SHALL, if alu_flags[0] stays low for DONE_TIMEOUT WAIT_DONE cycles, enter RESPOND with rsp_timeout=1, rsp_result=0 and rsp_flags=0.
REQ-021 SHALL allow a new accept on the IDLE cycle immediately after RESPOND; a req_valid seen during RESPOND is not accepted.

Reset
REQ-022 SHALL, on reset_n low, immediately force IDLE with alu_reset=1, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_id=0, rsp_timeout=0, reqN_ready=0, busy=0, alu_data=0, and the round-robin pointer to requester 0.
REQ-023 SHALL drop any in-flight job on reset mid-operation without issuing a response; alu_reset SHALL fall on the first clk edge after reset_n rises.

Configuration
REQ-024 SHALL, with ALU_SEQ_TIMEOUT_EN defined, implement the timeout counter and rsp_timeout as in REQ-020.
REQ-025 SHALL, without ALU_SEQ_TIMEOUT_EN, wait in WAIT_DONE indefinitely, omit the counter and tie rsp_timeout to 0.

Structure
REQ-026 SHALL take the FSM state enum, ALU opcode constants (ADD=0, SUB=1, AND=2, OR=3, NOT=4, NAND=5, NOR=6) and flag bit indices (done=0, carry=1, zero=2, sign=3) from the shared package alu_seq_pkg.
REQ-027 SHALL place the two-way round-robin arbitration in the sub-module rr_arbiter_2.

Verification
REQ-028 SHALL check: req0 op1=3, op2=4, opcode=0 with an ALU model -> rsp_valid 6 cycles after accept, rsp_id=0, rsp_result=7, rsp_flags=000.
REQ-029 SHALL check: req1 op1=9, op2=9, opcode=0 -> rsp_result=2, carry=1.
REQ-030 SHALL check: both valid at once for 4 jobs -> grants alternate 0,1,0,1 and responses carry matching rsp_id.
REQ-031 SHALL check, with ALU_SEQ_TIMEOUT_EN and DONE_TIMEOUT=8: alu_flags[0] stuck at 0 -> rsp_valid after 8 WAIT_DONE cycles, rsp_timeout=1, rsp_result=0.
REQ-032 SHALL check: reset_n pulsed low during SEND_OP2 -> IDLE immediately, no rsp_valid, alu_reset=1, and the next job completes normally.
REQ-033 SHALL check: req0_valid asserted during RESPOND -> accepted on the following IDLE cycle, with alu_data sequence 0, op1, op2, opcode.
